cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 37 +++
 rtl/cdb_result_buffer.sv | 60 ++++++
 rtl/cdb_arbiter.sv | 123 ++++++++++++
 tb/tb_cdb_arbiter.sv | 438 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared definitions for the common-data-bus arbiter slice.
// Supplies default core-wide widths (when the core has not already defined
// them), the CDB payload entry type and the result-buffer depth.
`ifndef NUM_OF_FU
`define NUM_OF_FU 4
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

package cdb_arbiter_pkg;

  // One broadcast payload: destination physical register, value and ROB tag.
  typedef struct packed {
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] addr;
    logic [`REG_VAL_WIDTH-1:0]          val;
    logic [`ROB_SIZE_WIDTH-1:0]         tag;
  } cdb_entry_t;

  localparam int CDB_BUF_DEPTH = 2;

  // Index reached by stepping 'offset' places round-robin from 'base' in a
  // ring of 'n' producers (base < n, offset < n, so one wrap is enough).
  function automatic int rr_wrap(input int base, input int offset, input int n);
    int sum;
    sum = base + offset;
    if (sum >= n) sum = sum - n;
    return sum;
  endfunction

endpackage

// File: rtl/cdb_result_buffer.sv
// Two-entry FIFO holding results produced by one functional unit until the
// arbiter grants them a CDB lane.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   flush           - synchronous discard of all held entries
//   push, push_data - write one entry (ignored when full or flushing)
//   pop             - drop the head entry (ignored when empty or flushing)
//   head            - oldest entry, meaningful while count != 0
//   count           - number of held entries (0..2)
module cdb_result_buffer
  import cdb_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  cdb_entry_t push_data,
  input  logic       pop,
  output cdb_entry_t head,
  output logic [1:0] count
);

  cdb_entry_t mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_push = push && (count != 2'd2) && !flush;
  assign do_pop  = pop && (count != 2'd0) && !flush;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping. A simultaneous push and pop leaves the
  // count unchanged while both pointers advance, which keeps FIFO order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter. Each functional unit writes results into its own
// two-entry buffer; every cycle up to NUM_CDB_PORTS non-empty buffers are
// granted round-robin and their head entries are registered onto the lanes.
// Ports:
//   clk, reset                         - clock, asynchronous active-high reset
//   flush                              - discard all buffered/pending results
//   fu_valid / fu_ready                - per-FU result handshake
//   fu_dst_addr, fu_val, fu_tag        - per-FU result payload
//   cdb_ready                          - all CDB consumers can take a broadcast
//   cdb_valid                          - per-lane broadcast strobe (one cycle)
//   cdb_register_addr, cdb_register_val, cdb_tag - per-lane payload
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_FU        = `NUM_OF_FU,
  parameter int NUM_CDB_PORTS = 2,
  parameter int BUF_DEPTH     = CDB_BUF_DEPTH
)(
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic                                                flush,
  input  logic [NUM_FU-1:0]                                   fu_valid,
  output logic [NUM_FU-1:0]                                   fu_ready,
  input  logic [NUM_FU-1:0][`PHYSICAL_REG_NUM_WIDTH-1:0]      fu_dst_addr,
  input  logic [NUM_FU-1:0][`REG_VAL_WIDTH-1:0]               fu_val,
  input  logic [NUM_FU-1:0][`ROB_SIZE_WIDTH-1:0]              fu_tag,
  input  logic                                                cdb_ready,
  output logic [NUM_CDB_PORTS-1:0]                            cdb_valid,
  output logic [NUM_CDB_PORTS-1:0][`PHYSICAL_REG_NUM_WIDTH-1:0] cdb_register_addr,
  output logic [NUM_CDB_PORTS-1:0][`REG_VAL_WIDTH-1:0]        cdb_register_val,
  output logic [NUM_CDB_PORTS-1:0][`ROB_SIZE_WIDTH-1:0]       cdb_tag
);

  localparam int         PTR_W      = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [1:0] FULL_COUNT = 2'(BUF_DEPTH);

  logic [1:0]               buf_count [NUM_FU];
  cdb_entry_t               buf_head  [NUM_FU];
  cdb_entry_t               fu_entry  [NUM_FU];
  logic [NUM_FU-1:0]        push;
  logic [NUM_FU-1:0]        grant;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         rr_next;
  logic [NUM_CDB_PORTS-1:0] lane_valid;
  cdb_entry_t               lane_data [NUM_CDB_PORTS];

  // Readiness depends only on buffer occupancy and flush, never on cdb_ready,
  // so a stalled bus cannot form a combinational loop back into the FUs.
  for (genvar i = 0; i < NUM_FU; i++) begin : g_buf
    assign fu_ready[i] = (buf_count[i] < FULL_COUNT) && !flush;
    assign push[i]     = fu_valid[i] && fu_ready[i];
    assign fu_entry[i] = '{addr: fu_dst_addr[i], val: fu_val[i], tag: fu_tag[i]};

    cdb_result_buffer u_buf (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .push      (push[i]),
      .push_data (fu_entry[i]),
      .pop       (grant[i]),
      .head      (buf_head[i]),
      .count     (buf_count[i])
    );
  end

  // Multi-grant round-robin: walk the FUs starting at rr_ptr and hand the
  // k-th non-empty buffer to lane k until the lanes run out. The pointer then
  // moves just past the last winner so that FU gets lowest priority next time.
  always_comb begin
    int idx;
    int n_granted;
    grant      = '0;
    lane_valid = '0;
    rr_next    = rr_ptr;
    n_granted  = 0;
    idx        = 0;
    for (int k = 0; k < NUM_CDB_PORTS; k++) lane_data[k] = '0;
    if (cdb_ready && !flush) begin
      for (int j = 0; j < NUM_FU; j++) begin
        idx = rr_wrap(int'(rr_ptr), j, NUM_FU);
        for (int i = 0; i < NUM_FU; i++) begin
          if ((i == idx) && (buf_count[i] != 2'd0) && (n_granted < NUM_CDB_PORTS)) begin
            grant[i] = 1'b1;
            for (int k = 0; k < NUM_CDB_PORTS; k++) begin
              if (n_granted == k) begin
                lane_valid[k] = 1'b1;
                lane_data[k]  = buf_head[i];
              end
            end
            n_granted = n_granted + 1;
            rr_next   = PTR_W'(rr_wrap(i, 1, NUM_FU));
          end
        end
      end
    end
  end

  // Lane output registers and round-robin pointer. Payloads only reload on
  // lanes that carry a result; cdb_valid is rebuilt every cycle so each
  // broadcast is a one-cycle pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr            <= '0;
      cdb_valid         <= '0;
      cdb_register_addr <= '0;
      cdb_register_val  <= '0;
      cdb_tag           <= '0;
    end else if (flush) begin
      cdb_valid <= '0;
    end else begin
      rr_ptr    <= rr_next;
      cdb_valid <= lane_valid;
      for (int k = 0; k < NUM_CDB_PORTS; k++) begin
        if (lane_valid[k]) begin
          cdb_register_addr[k] <= lane_data[k].addr;
          cdb_register_val[k]  <= lane_data[k].val;
          cdb_tag[k]           <= lane_data[k].tag;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed scenarios on a 4-FU/2-lane
// instance, a fairness scenario on a 4-FU/1-lane instance, and a randomized
// run compared against a queue-based reference model.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int AW = `PHYSICAL_REG_NUM_WIDTH;
  localparam int VW = `REG_VAL_WIDTH;
  localparam int TW = `ROB_SIZE_WIDTH;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  // Main instance: 4 FUs, 2 lanes.
  logic [3:0]         fu_valid;
  logic [3:0]         fu_ready;
  logic [3:0][AW-1:0] fu_dst_addr;
  logic [3:0][VW-1:0] fu_val;
  logic [3:0][TW-1:0] fu_tag;
  logic               cdb_ready;
  logic [1:0]         cdb_valid;
  logic [1:0][AW-1:0] cdb_register_addr;
  logic [1:0][VW-1:0] cdb_register_val;
  logic [1:0][TW-1:0] cdb_tag;

  // Fairness instance: 4 FUs, 1 lane.
  logic [3:0]         fu_valid1;
  logic [3:0]         fu_ready1;
  logic [3:0][AW-1:0] fu_dst_addr1;
  logic [3:0][VW-1:0] fu_val1;
  logic [3:0][TW-1:0] fu_tag1;
  logic [0:0]         cdb_valid1;
  logic [0:0][AW-1:0] cdb_register_addr1;
  logic [0:0][VW-1:0] cdb_register_val1;
  logic [0:0][TW-1:0] cdb_tag1;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per FU plus an integer round-robin start.
  cdb_entry_t mq [4][$];
  int         m_rr;
  bit         exp_valid [2];
  cdb_entry_t exp_entry [2];

  always #5 clk = ~clk;

  cdb_arbiter #(.NUM_FU(4), .NUM_CDB_PORTS(2)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .fu_valid(fu_valid), .fu_ready(fu_ready),
    .fu_dst_addr(fu_dst_addr), .fu_val(fu_val), .fu_tag(fu_tag),
    .cdb_ready(cdb_ready), .cdb_valid(cdb_valid),
    .cdb_register_addr(cdb_register_addr), .cdb_register_val(cdb_register_val),
    .cdb_tag(cdb_tag)
  );

  cdb_arbiter #(.NUM_FU(4), .NUM_CDB_PORTS(1)) dut1 (
    .clk(clk), .reset(reset), .flush(flush),
    .fu_valid(fu_valid1), .fu_ready(fu_ready1),
    .fu_dst_addr(fu_dst_addr1), .fu_val(fu_val1), .fu_tag(fu_tag1),
    .cdb_ready(1'b1), .cdb_valid(cdb_valid1),
    .cdb_register_addr(cdb_register_addr1), .cdb_register_val(cdb_register_val1),
    .cdb_tag(cdb_tag1)
  );

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_rr = 0;
    exp_valid[0] = 1'b0;
    exp_valid[1] = 1'b0;
  endtask

  // Applies the behavioural rules at one rising edge using the inputs present.
  task automatic model_edge();
    bit         ready_pre [4];
    int         ng;
    int         last;
    int         idx;
    cdb_entry_t e;
    for (int i = 0; i < 4; i++) ready_pre[i] = (mq[i].size() < 2) && !flush;
    exp_valid[0] = 1'b0;
    exp_valid[1] = 1'b0;
    if (flush) begin
      for (int i = 0; i < 4; i++) mq[i].delete();
    end else begin
      ng   = 0;
      last = -1;
      if (cdb_ready) begin
        for (int j = 0; j < 4; j++) begin
          idx = (m_rr + j) % 4;
          if (mq[idx].size() > 0 && ng < 2) begin
            exp_entry[ng] = mq[idx].pop_front();
            exp_valid[ng] = 1'b1;
            ng++;
            last = idx;
          end
        end
      end
      if (last >= 0) m_rr = (last + 1) % 4;
      for (int i = 0; i < 4; i++) begin
        if (fu_valid[i] && ready_pre[i]) begin
          e.addr = fu_dst_addr[i];
          e.val  = fu_val[i];
          e.tag  = fu_tag[i];
          mq[i].push_back(e);
        end
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b expected 00", cdb_valid);
    end
    checks++;
    if (fu_ready !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL reset_ready: got %b expected 1111", fu_ready);
    end
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (int'(dut.rr_ptr) !== 0) begin
      errors++;
      $display("[TB] FAIL reset_rr: got %0d expected 0", dut.rr_ptr);
    end
  endtask

  task automatic test_single();
    fu_valid       = 4'b0100;
    fu_dst_addr[2] = AW'(5);
    fu_val[2]      = 32'hDEADBEEF;
    fu_tag[2]      = TW'(3);
    cdb_ready      = 1'b1;
    #1;
    cycle();
    fu_valid = 4'b0000;
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_early: got %b expected 00", cdb_valid);
    end
    cycle();
    checks++;
    if (cdb_valid !== 2'b01 || cdb_register_addr[0] !== AW'(5) ||
        cdb_register_val[0] !== 32'hDEADBEEF || cdb_tag[0] !== TW'(3)) begin
      errors++;
      $display("[TB] FAIL single_lane0: got v=%b a=%0d d=%h t=%0d expected v=01 a=5 d=deadbeef t=3",
               cdb_valid, cdb_register_addr[0], cdb_register_val[0], cdb_tag[0]);
    end
    checks++;
    if (int'(dut.rr_ptr) !== 3) begin
      errors++;
      $display("[TB] FAIL single_rr: got %0d expected 3", dut.rr_ptr);
    end
    cycle();
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++;
      $display("[TB] FAIL single_pulse: got %b expected 00", cdb_valid);
    end
  endtask

  task automatic test_contention();
    reset = 1'b1;
    #1;
    model_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fu_dst_addr[i] = AW'(10 + i);
      fu_val[i]      = VW'(32'h100 * (i + 1));
      fu_tag[i]      = TW'(i);
    end
    fu_valid  = 4'b1111;
    cdb_ready = 1'b1;
    #1;
    cycle();
    fu_valid = 4'b0000;
    cycle();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_tag[0] !== TW'(0) || cdb_tag[1] !== TW'(1)) begin
      errors++;
      $display("[TB] FAIL contention_c1: got v=%b t0=%0d t1=%0d expected v=11 t0=0 t1=1",
               cdb_valid, cdb_tag[0], cdb_tag[1]);
    end
    cycle();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_tag[0] !== TW'(2) || cdb_tag[1] !== TW'(3) ||
        cdb_register_addr[1] !== AW'(13)) begin
      errors++;
      $display("[TB] FAIL contention_c2: got v=%b t0=%0d t1=%0d a1=%0d expected v=11 t0=2 t1=3 a1=13",
               cdb_valid, cdb_tag[0], cdb_tag[1], cdb_register_addr[1]);
    end
    checks++;
    if (int'(dut.rr_ptr) !== 0) begin
      errors++;
      $display("[TB] FAIL contention_rr: got %0d expected 0", dut.rr_ptr);
    end
    cycle();
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++;
      $display("[TB] FAIL contention_idle: got %b expected 00", cdb_valid);
    end
  endtask

  task automatic test_backpressure();
    cdb_ready = 1'b0;
    fu_valid  = 4'b0001;
    for (int c = 0; c < 3; c++) begin
      fu_tag[0]      = TW'(c + 5);
      fu_dst_addr[0] = AW'(c + 20);
      #1;
      checks++;
      if (fu_ready[0] !== (c < 2)) begin
        errors++;
        $display("[TB] FAIL bp_ready%0d: got %b expected %b", c, fu_ready[0], (c < 2));
      end
      cycle();
      checks++;
      if (cdb_valid !== 2'b00) begin
        errors++;
        $display("[TB] FAIL bp_stall%0d: got %b expected 00", c, cdb_valid);
      end
    end
    fu_valid  = 4'b0000;
    cdb_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      checks++;
      if (cdb_valid !== 2'b01 || cdb_tag[0] !== TW'(c + 5) || cdb_register_addr[0] !== AW'(c + 20)) begin
        errors++;
        $display("[TB] FAIL bp_drain%0d: got v=%b t=%0d a=%0d expected v=01 t=%0d a=%0d",
                 c, cdb_valid, cdb_tag[0], cdb_register_addr[0], c + 5, c + 20);
      end
    end
    cycle();
    checks++;
    if (cdb_valid !== 2'b00) begin
      errors++;
      $display("[TB] FAIL bp_done: got %b expected 00", cdb_valid);
    end
  endtask

  task automatic test_flush();
    cdb_ready = 1'b0;
    fu_valid  = 4'b1111;
    repeat (2) begin
      #1;
      cycle();
    end
    checks++;
    if (fu_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL flush_full: got %b expected 0000", fu_ready);
    end
    cdb_ready = 1'b1;
    flush     = 1'b1;
    #1;
    checks++;
    if (fu_ready !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL flush_ready_during: got %b expected 0000", fu_ready);
    end
    cycle();
    flush    = 1'b0;
    fu_valid = 4'b0000;
    #1;
    checks++;
    if (cdb_valid !== 2'b00 || fu_ready !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL flush_after: got v=%b r=%b expected v=00 r=1111", cdb_valid, fu_ready);
    end
    for (int c = 0; c < 4; c++) begin
      cycle();
      checks++;
      if (cdb_valid !== 2'b00) begin
        errors++;
        $display("[TB] FAIL flush_stale%0d: got %b expected 00", c, cdb_valid);
      end
    end
  endtask

  task automatic test_async_reset();
    cdb_ready = 1'b0;
    fu_valid  = 4'b1111;
    #1;
    cycle();
    fu_valid  = 4'b0000;
    cdb_ready = 1'b1;
    cycle();
    checks++;
    if (cdb_valid !== 2'b11) begin
      errors++;
      $display("[TB] FAIL areset_draining: got %b expected 11", cdb_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (cdb_valid !== 2'b00 || fu_ready !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL areset_immediate: got v=%b r=%b expected v=00 r=1111", cdb_valid, fu_ready);
    end
    model_reset();
    #1;
    reset = 1'b0;
    fu_valid    = 4'b1001;
    fu_tag[0]   = TW'(4'hA);
    fu_tag[3]   = TW'(4'hB);
    #1;
    cycle();
    fu_valid = 4'b0000;
    cycle();
    checks++;
    if (cdb_valid !== 2'b11 || cdb_tag[0] !== TW'(4'hA) || cdb_tag[1] !== TW'(4'hB)) begin
      errors++;
      $display("[TB] FAIL areset_priority: got v=%b t0=%h t1=%h expected v=11 t0=a t1=b",
               cdb_valid, cdb_tag[0], cdb_tag[1]);
    end
    cycle();
  endtask

  task automatic test_fairness();
    int want;
    fu_valid1       = 4'b1001;
    fu_dst_addr1[0] = AW'(0);
    fu_dst_addr1[3] = AW'(3);
    #1;
    cycle();
    for (int k = 0; k < 8; k++) begin
      cycle();
      want = (k % 2 == 0) ? 0 : 3;
      checks++;
      if (cdb_valid1 !== 1'b1 || int'(cdb_register_addr1[0]) !== want) begin
        errors++;
        $display("[TB] FAIL fair_grant%0d: got v=%b fu=%0d expected v=1 fu=%0d",
                 k, cdb_valid1, cdb_register_addr1[0], want);
      end
    end
    fu_valid1 = 4'b0000;
    repeat (4) cycle();
  endtask

  task automatic test_random();
    logic [3:0] exp_ready;
    logic [1:0] ev;
    for (int n = 0; n < 400; n++) begin
      fu_valid  = 4'($urandom);
      cdb_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      for (int i = 0; i < 4; i++) begin
        fu_dst_addr[i] = AW'($urandom);
        fu_val[i]      = VW'($urandom);
        fu_tag[i]      = TW'($urandom);
      end
      #1;
      for (int i = 0; i < 4; i++) exp_ready[i] = (mq[i].size() < 2) && !flush;
      checks++;
      if (fu_ready !== exp_ready) begin
        errors++;
        $display("[TB] FAIL rand_ready@%0d: got %b expected %b", n, fu_ready, exp_ready);
      end
      cycle();
      ev = {exp_valid[1], exp_valid[0]};
      checks++;
      if (cdb_valid !== ev) begin
        errors++;
        $display("[TB] FAIL rand_valid@%0d: got %b expected %b", n, cdb_valid, ev);
      end
      for (int k = 0; k < 2; k++) begin
        if (exp_valid[k]) begin
          checks++;
          if ({cdb_register_addr[k], cdb_register_val[k], cdb_tag[k]} !== exp_entry[k]) begin
            errors++;
            $display("[TB] FAIL rand_lane%0d@%0d: got %h expected %h", k, n,
                     {cdb_register_addr[k], cdb_register_val[k], cdb_tag[k]}, exp_entry[k]);
          end
        end
      end
    end
    flush     = 1'b0;
    fu_valid  = 4'b0000;
    cdb_ready = 1'b1;
    cycle();
    checks++;
    if (int'(dut.rr_ptr) !== m_rr) begin
      errors++;
      $display("[TB] FAIL rand_rr: got %0d expected %0d", dut.rr_ptr, m_rr);
    end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    flush        = 1'b0;
    cdb_ready    = 1'b1;
    fu_valid     = '0;
    fu_dst_addr  = '0;
    fu_val       = '0;
    fu_tag       = '0;
    fu_valid1    = '0;
    fu_dst_addr1 = '0;
    fu_val1      = '0;
    fu_tag1      = '0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_fairness();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
